// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one request outstanding to the I-cache, and feeds IF/ID.
// Optional FETCH_STATS_EN adds fetchCount/redirectCount.
//   state | meaning
//   FETCH | request at pc outstanding
//   DRAIN | redirect seen mid-request; wait for ack, discard data
//   FULL  | acked instruction parked in buffer during stall; no request
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchFlag,
  input  logic [31:0] branchAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        instValid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] redirectCount
`endif
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] br_tgt;
  logic        unused_addr_bits;

  assign br_tgt           = {branchAddr[31:2], 2'b00};
  assign unused_addr_bits = ^branchAddr[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_tgt_d  = redir_tgt_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      ST_FETCH: begin
        if (imemAck) begin
          if (branchFlag) begin
            pc_d = br_tgt;
          end else if (!stall) begin
            pc_out_d     = pc_q;
            inst_out_d   = imemData;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            buf_pc_d   = pc_q;
            buf_inst_d = imemData;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_FULL;
          end
        end else begin
          // The request must stay stable until acked, so park the target instead.
          if (branchFlag) begin
            redir_tgt_d = br_tgt;
            state_d     = ST_DRAIN;
          end
          if (!stall) inst_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (imemAck) begin
          pc_d    = branchFlag ? br_tgt : redir_tgt_q;
          state_d = ST_FETCH;
        end else if (branchFlag) begin
          redir_tgt_d = br_tgt;
        end
        if (!stall) inst_valid_d = 1'b0;
      end
      ST_FULL: begin
        if (branchFlag) begin
          buf_pc_d   = 32'd0;
          buf_inst_d = 32'd0;
          pc_d       = br_tgt;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          pc_out_d     = buf_pc_q;
          inst_out_d   = buf_inst_q;
          inst_valid_d = 1'b1;
          buf_pc_d     = 32'd0;
          buf_inst_d   = 32'd0;
          state_d      = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // A redirect squashes whatever is presented, even under stall.
    if (branchFlag) inst_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC_ALIGNED;
      redir_tgt_q  <= 32'd0;
      buf_pc_q     <= 32'd0;
      buf_inst_q   <= 32'd0;
      pc_out_q     <= 32'd0;
      inst_out_q   <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_tgt_q  <= redir_tgt_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imemReq   = (state_q != ST_FULL);
  assign imemAddr  = pc_q;
  assign pcOut     = pc_out_q;
  assign instOut   = inst_out_q;
  assign instValid = inst_valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redirect_count_q, redirect_count_d;
  logic        fetch_load;

  assign fetch_load = !branchFlag && !stall &&
                      (((state_q == ST_FETCH) && imemAck) || (state_q == ST_FULL));

  always_comb begin
    fetch_count_d    = fetch_count_q;
    redirect_count_d = redirect_count_q;
    if (fetch_load) fetch_count_d = fetch_count_q + 32'd1;
    if (branchFlag) redirect_count_d = redirect_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q    <= 32'd0;
      redirect_count_q <= 32'd0;
    end else begin
      fetch_count_q    <= fetch_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign fetchCount    = fetch_count_q;
  assign redirectCount = redirect_count_q;
`endif

endmodule
